// File: rtl/vec_mem_pkg.sv
// Shared types and constants for the vector memory-stage sequencer.
package vec_mem_pkg;

  localparam int VMS_N          = 32;
  localparam int VMS_LANES      = 4;
  localparam int VMS_V          = VMS_N * VMS_LANES;
  localparam int LANE_BYTES     = 4;
  localparam int VMS_LANE_CNT_W = $clog2(VMS_LANES);

  localparam logic [31:0] VMS_ADDR_LIMIT = 32'h0004_AFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } vms_state_e;

endpackage

// File: rtl/vms_addr_gen.sv
// Per-beat address: base + lane*LANE_BYTES with natural wrap, then the
// data-memory clamp (anything above ADDR_LIMIT is driven as address 0).
module vms_addr_gen
  import vec_mem_pkg::*;
#(
  parameter int            N          = VMS_N,
  parameter int            LW         = VMS_LANE_CNT_W,
  parameter logic [N-1:0]  ADDR_LIMIT = VMS_ADDR_LIMIT
) (
  input  logic [N-1:0]  base_addr,
  input  logic [LW-1:0] lane,
  output logic [N-1:0]  beat_addr
);

  logic [N-1:0] lane_offset;
  logic [N-1:0] raw_addr;

  assign lane_offset = N'(lane) * N'(LANE_BYTES);
  assign raw_addr    = base_addr + lane_offset;
  assign beat_addr   = (raw_addr > ADDR_LIMIT) ? '0 : raw_addr;

endmodule

// File: rtl/vec_mem_sequencer.sv
// Memory-stage controller: scalar accesses pass straight through, vector
// accesses are split into LANES consecutive beats while the pipe is stalled.
module vec_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int           N          = VMS_N,
  parameter int           V          = VMS_V,
  parameter int           LANES      = VMS_LANES,
  parameter logic [N-1:0] ADDR_LIMIT = VMS_ADDR_LIMIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic         req_vector,
  input  logic [N-1:0] req_addr,
  input  logic [V-1:0] req_wdata,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  output logic [V-1:0] rsp_rdata,
  output logic         stall,
  output logic         busy
);

  localparam int            LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  vms_state_e    state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [V-1:0]  lane_buf_q, lane_buf_d;

  logic [LW-1:0] lane_idx;
  logic [N-1:0]  beat_addr;
  logic [N-1:0]  beat_wdata;
  logic          capture;

  // Lane 0 is issued from IDLE, so the counter only steers the mux in BEAT.
  assign lane_idx   = (state_q == BEAT) ? cnt_q : '0;
  assign beat_wdata = req_wdata[N*int'(lane_idx) +: N];

  vms_addr_gen #(
    .N          (N),
    .LW         (LW),
    .ADDR_LIMIT (ADDR_LIMIT)
  ) u_addr_gen (
    .base_addr (req_addr),
    .lane      (lane_idx),
    .beat_addr (beat_addr)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_buf_d = lane_buf_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_vector && mem_ready) begin
          capture = 1'b1;
          if (LAST_LANE == '0) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = BEAT;
            cnt_d   = LW'(1);
          end
        end
      end
      BEAT: begin
        if (mem_ready) begin
          capture = 1'b1;
          if (cnt_q == LAST_LANE) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // The request is still on the inputs here; it must not restart.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (capture) begin
      lane_buf_d[N*int'(lane_idx) +: N] = mem_rdata;
    end
  end

  // Outputs are combinational on state and request; reset forces them quiet.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    stall     = 1'b0;
    busy      = 1'b0;
    rsp_rdata = '0;
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mem_addr  = beat_addr;
            mem_wdata = beat_wdata;
            mem_we    = req_write & mem_ready;
            if (req_vector) begin
              stall = 1'b1;
            end else begin
              stall     = ~mem_ready;
              rsp_rdata = V'(mem_rdata);
            end
          end
        end
        BEAT: begin
          mem_addr  = beat_addr;
          mem_wdata = beat_wdata;
          mem_we    = req_write & mem_ready;
          stall     = 1'b1;
          rsp_rdata = lane_buf_q;
        end
        DONE: begin
          rsp_rdata = lane_buf_q;
        end
        default: begin
          rsp_rdata = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lane_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_buf_q <= lane_buf_d;
    end
  end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
Memory-stage controller that sequences 128-bit vector loads and stores over the 32-bit data-memory port as four consecutive lane beats.
- Sits between the EX/MEM pipe register outputs and external data memory.
- Stalls the pipeline while a vector access is in flight.
- Scalar accesses pass through in one cycle.
- Applies the data-memory address clamp on every beat.

Parameters:
N, 32, scalar/lane width and address width
V, 128, vector width (V = LANES*N)
LANES, 4, lanes per vector
ADDR_LIMIT, 32'h4AFFF, highest legal data address; any beat address above it is driven as 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  memory-stage instruction accesses memory (load or store)
req_write  in  1  1 = store, 0 = load
req_vector  in  1  1 = vector access, 0 = scalar
req_addr  in  N  base byte address (ALU result, memory stage)
req_wdata  in  V  store data; lane i = bits [N*i+N-1 : N*i]
mem_ready  in  1  memory port granted/ready this cycle (shared with DMA)
mem_rdata  in  N  combinational read data for mem_addr
mem_addr  out  N  beat address
mem_wdata  out  N  beat store data
mem_we  out  1  beat write enable
rsp_rdata  out  V  load result to MEM/WB pipe and forwarding mux
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM, MEM/WB
busy  out  1  sequencer not in IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE, lane counter=0, lane buffer=0.
  - stall=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_rdata=0.
  - A reset mid-sequence abandons the access; partial stores already written remain.
- Beat address: lane i uses req_addr + 4*i, modulo 2^N (wraps). If the result is > ADDR_LIMIT, the beat address is 0. The clamp is applied per lane.
- IDLE, req_valid=0:
  - mem_we=0, mem_addr=0, stall=0, rsp_rdata=0.
- IDLE, scalar request:
  - mem_addr = clamp(req_addr), mem_wdata = lane 0 of req_wdata.
  - mem_we = req_write & mem_ready.
  - rsp_rdata = zero-extended mem_rdata.
  - stall = ~mem_ready.
  - State stays IDLE.
- IDLE, vector request:
  - Issue lane 0 combinationally, with mem_we = req_write & mem_ready. stall=1.
  - If mem_ready=1: capture mem_rdata into buffer lane 0, set counter=1, go to BEAT.
  - If mem_ready=0: remain in IDLE, retry next cycle.
- BEAT (counter k = 1..LANES-1):
  - Drive lane k; stall=1; mem_we = req_write & mem_ready.
  - On mem_ready=1: capture lane k and increment k. After lane LANES-1 is captured, go to DONE.
  - On mem_ready=0: hold k, address and data; nothing is captured.
- DONE (one cycle):
  - stall=0, mem_we=0, rsp_rdata = buffer (all lanes); the pipeline advances.
  - Always go to IDLE. The still-present request in this cycle is never re-issued.
- Latency:
  - Vector access with mem_ready held high: 4 stall cycles + 1 DONE cycle = 5 cycles.
  - Scalar access: 0 stall cycles.
- Back-to-back vectors: a new vector request is accepted in the IDLE cycle after DONE.
- Request fields are held stable by the stall. The block does not register req_* and relies on that stability.
- Stores: the buffer still captures mem_rdata. rsp_rdata on a store is don't-care to the pipeline but is deterministic (the buffer contents).
- busy = (state != IDLE).

Decomposition:
Shared package vec_mem_pkg:
- state enum {IDLE, BEAT, DONE}
- LANE_BYTES = 4
- lane-count width localparam $clog2(LANES)
- ADDR_LIMIT default

One sub-module, vms_addr_gen (combinational): base + lane*LANE_BYTES, wrap, ADDR_LIMIT clamp. It is instantiated once, fed by the lane index mux.

Test Plan:
1. Scalar load, addr 0x100, mem_rdata=0xDEADBEEF, mem_ready=1 -> same cycle mem_addr=0x100, stall=0, rsp_rdata=0x...0_DEADBEEF.
2. Vector load, base 0x200, memory words 0x11,0x22,0x33,0x44 -> addresses 0x200,0x204,0x208,0x20C on consecutive cycles; stall=1 for 4 cycles; DONE cycle rsp_rdata=0x00000044_00000033_00000022_00000011, stall=0.
3. Vector store, base 0x4AFF8, wdata lanes A,B,C,D -> addresses 0x4AFF8, 0x4AFFC, 0, 0 (clamp); mem_we=1 for exactly 4 cycles; lanes C and D written to address 0.
4. Vector load with mem_ready dropped for 2 cycles during lane 2 -> mem_addr held at base+8; total occupancy 7 cycles; buffer correct.
5. Reset asserted mid-BEAT (lane 1), asynchronously -> stall, mem_we and busy go to 0 before the next edge; next request starts from lane 0.
6. Two vector loads back-to-back, then a scalar load -> second vector starts the cycle after DONE; the scalar passes through with no stall; no duplicate beats.
